sm_stack: RTL and testbench
===========================

SM_STACK -- requirements
Module: sm_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width.
REQ-002 SHALL have parameter DEPTH, default 32, meaning entry count (power of two).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port push  input  1  push request, sampled at clk rise.
REQ-006 SHALL have port push_data  input  WIDTH  word to push.
REQ-007 SHALL have port pop  input  1  pop request, sampled at clk rise.
REQ-008 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port pop_data  output  WIDTH  registered popped word.
REQ-010 SHALL have port pop_valid  output  1  one-cycle pulse qualifying pop_data.
REQ-011 SHALL have port top  output  WIDTH  current top-of-stack word (0 when empty).
REQ-012 SHALL have port sp  output  log2(DEPTH)  stack pointer, next free slot.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  occupied entries.
REQ-014 SHALL have port full / empty  output  1 each  count==DEPTH / count==0.
REQ-015 SHALL have ports err_ovf / err_unf  output  1 each  sticky overflow / underflow.

Function
REQ-016 Stack SHALL grow downward: sp = (DEPTH-1) - count, modulo DEPTH; sp is all-ones when empty.
REQ-017 Accepted push alone SHALL write mem[sp] <= push_data, count+1, sp-1 in the same edge.
REQ-018 Accepted pop alone SHALL load pop_data <= mem[sp+1], pulse pop_valid the next cycle, count-1, sp+1.
REQ-019 pop_data SHALL hold its last value when pop_valid is low.
REQ-020 push+pop with count>0 SHALL return old top on pop_data/pop_valid, overwrite the top entry with push_data, and leave count/sp unchanged; this holds when full.
REQ-021 push+pop with count==0 SHALL accept the push, reject the pop, and set err_unf; pop_valid stays low.
REQ-022 Push alone when full SHALL be dropped (memory, count unchanged) and set err_ovf.
REQ-023 Pop alone when empty SHALL be ignored and set err_unf.
REQ-024 err_ovf/err_unf SHALL remain set until clr_err; clr_err and a new error in the same cycle SHALL leave the flag set.
REQ-025 top, full, empty, sp, count SHALL reflect the state after the last clock edge, no combinational path from push/pop.
REQ-026 When full, sp wraps to all-ones; full, not sp, distinguishes full from empty.

Reset
REQ-027 rst high SHALL immediately force count=0, sp=all-ones, empty=1, full=0, pop_valid=0, pop_data=0, top=0, err_ovf=0, err_unf=0.
REQ-028 Memory contents SHALL NOT be reset; stale data SHALL never be visible on top or pop_data.
REQ-029 rst asserted mid-operation SHALL discard any in-flight pop; pop_valid SHALL not pulse after reset release without a new pop.

Structure
REQ-030 Package sm_stack_pkg SHALL hold DEPTH, WIDTH, PTR_W=log2(DEPTH), CNT_W=PTR_W+1 defaults.
REQ-031 Storage SHALL be a sub-module sm_stack_mem: DEPTH x WIDTH, one synchronous write port, one asynchronous read port, no reset.
REQ-032 Control (count, sp, flags, pop_data register) SHALL live in sm_stack; expected size 120-400 lines total.

Verification
REQ-033 Reset then push 0x11,0x22,0x33 -> count=3, sp=28, top=0x33, empty=0.
REQ-034 Three pops after REQ-033 -> pop_data 0x33,0x22,0x11 each one cycle after request with pop_valid pulses; then empty=1, sp=31, top=0.
REQ-035 32 pushes of 0..31 then push 0xFF -> full=1, sp=31, err_ovf=1, top=31; clr_err -> err_ovf=0.
REQ-036 Full stack, push 0xAA + pop same cycle -> pop_data=31, top=0xAA, count=32.
REQ-037 Empty stack, push 0x55 + pop same cycle -> err_unf=1, no pop_valid, count=1, top=0x55.
REQ-038 rst pulsed mid-edge during a pop with count=5 -> all outputs at reset values immediately, no pop_valid after release.

Source files
------------

// File: rtl/sm_stack_pkg.sv
// Shared definitions for the downward-growing stack.
//   WIDTH, DEPTH  : default data width and entry count
//   PTR_W, CNT_W  : stack-pointer and occupancy-counter widths
//   op_e          : decoded request for one clock edge
package sm_stack_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11   // push and pop in the same cycle
  } op_e;

endpackage

// File: rtl/sm_stack_mem.sv
// Stack storage: DEPTH x WIDTH words, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
module sm_stack_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: no reset on the array so it maps onto RAM; the control logic
  // guarantees never-written or stale slots are never exposed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sm_stack.sv
// Downward-growing LIFO stack with sticky overflow/underflow flags.
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : push request and word
//   pop               : pop request
//   clr_err           : clears sticky error flags
//   pop_data          : registered popped word, held between pops
//   pop_valid         : one-cycle pulse qualifying pop_data
//   top               : current top-of-stack word (0 when empty)
//   sp                : next free slot, (DEPTH-1) - count modulo DEPTH
//   count             : occupied entries
//   full, empty       : count==DEPTH / count==0
//   err_ovf, err_unf  : sticky overflow / underflow
module sm_stack
  import sm_stack_pkg::*;
#(
  parameter int WIDTH = sm_stack_pkg::WIDTH,
  parameter int DEPTH = sm_stack_pkg::DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top,
  output logic [PW-1:0]    sp,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_unf
);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  logic             mem_we;
  logic [PW-1:0]    mem_waddr;
  logic [PW-1:0]    top_addr;
  logic [WIDTH-1:0] top_word;
  op_e              op;

  // Status is derived from count_q only, so no path from push/pop.
  // (DEPTH-1) - count mod DEPTH is the bitwise inverse of count's low bits;
  // when full the low bits are zero and sp wraps to all-ones.
  assign sp       = ~count_q[PW-1:0];
  assign top_addr = sp + PW'(1);
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

  assign op = op_e'({push, pop});

  sm_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (push_data),
    .raddr (top_addr),
    .rdata (top_word)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    err_ovf_d   = err_ovf_q & ~clr_err;
    err_unf_d   = err_unf_q & ~clr_err;
    mem_we      = 1'b0;
    mem_waddr   = sp;

    unique case (op)
      OP_PUSH: begin
        if (full) begin
          err_ovf_d = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          err_unf_d = 1'b1;
        end else begin
          pop_valid_d = 1'b1;
          pop_data_d  = top_word;
          count_d     = count_q - CW'(1);
        end
      end
      OP_SWAP: begin
        if (empty) begin
          // Pop has nothing to return; the push still lands.
          err_unf_d = 1'b1;
          mem_we    = 1'b1;
          count_d   = count_q + CW'(1);
        end else begin
          // Return the old top and overwrite it in place; works when full.
          pop_valid_d = 1'b1;
          pop_data_d  = top_word;
          mem_we      = 1'b1;
          mem_waddr   = top_addr;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

  assign count     = count_q;
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;
  // Gate the read port so unwritten/stale slots never show when empty.
  assign top       = empty ? '0 : top_word;

endmodule

// File: tb/tb_sm_stack.sv
// Directed self-checking bench for sm_stack with default parameters.
module tb_sm_stack;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;

  logic             clk;
  logic             rst;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top;
  logic [4:0]       sp;
  logic [5:0]       count;
  logic             full;
  logic             empty;
  logic             err_ovf;
  logic             err_unf;

  int total = 0;
  int bad   = 0;

  sm_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clr_err   (clr_err),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .top       (top),
    .sp        (sp),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".count"},     64'(count),     64'd0);
    check({tag, ".sp"},        64'(sp),        64'd31);
    check({tag, ".empty"},     64'(empty),     64'd1);
    check({tag, ".full"},      64'(full),      64'd0);
    check({tag, ".pop_valid"}, 64'(pop_valid), 64'd0);
    check({tag, ".pop_data"},  64'(pop_data),  64'd0);
    check({tag, ".top"},       64'(top),       64'd0);
    check({tag, ".err_ovf"},   64'(err_ovf),   64'd0);
    check({tag, ".err_unf"},   64'(err_unf),   64'd0);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = '0;
    #3;
    check_reset_state("rst0");
    step();
    rst = 1'b0;

    // Three pushes.
    push = 1'b1;
    push_data = 32'h11; step();
    push_data = 32'h22; step();
    push_data = 32'h33; step();
    push = 1'b0;
    check("p3.count", 64'(count), 64'd3);
    check("p3.sp",    64'(sp),    64'd28);
    check("p3.top",   64'(top),   64'h33);
    check("p3.empty", 64'(empty), 64'd0);

    // Three pops, LIFO order, each valid one cycle after the request.
    pop = 1'b1; step();
    check("pop1.valid", 64'(pop_valid), 64'd1);
    check("pop1.data",  64'(pop_data),  64'h33);
    check("pop1.top",   64'(top),       64'h22);
    step();
    check("pop2.valid", 64'(pop_valid), 64'd1);
    check("pop2.data",  64'(pop_data),  64'h22);
    step();
    check("pop3.valid", 64'(pop_valid), 64'd1);
    check("pop3.data",  64'(pop_data),  64'h11);
    pop = 1'b0; step();
    check("idle.valid", 64'(pop_valid), 64'd0);
    check("idle.hold",  64'(pop_data),  64'h11);
    check("idle.empty", 64'(empty),     64'd1);
    check("idle.sp",    64'(sp),        64'd31);
    check("idle.top",   64'(top),       64'd0);

    // Fill to full with 0..31, then one push too many.
    push = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push_data = 32'(i); step();
    end
    check("fill.full",  64'(full),  64'd1);
    check("fill.count", 64'(count), 64'd32);
    check("fill.sp",    64'(sp),    64'd31);
    check("fill.top",   64'(top),   64'd31);
    check("fill.ovf0",  64'(err_ovf), 64'd0);
    push_data = 32'hFF; step();
    push = 1'b0;
    check("ovf.flag",  64'(err_ovf), 64'd1);
    check("ovf.count", 64'(count),   64'd32);
    check("ovf.top",   64'(top),     64'd31);
    step();
    check("ovf.sticky", 64'(err_ovf), 64'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("ovf.clr", 64'(err_ovf), 64'd0);

    // Push+pop while full: old top returned, top replaced, count kept.
    push = 1'b1; pop = 1'b1; push_data = 32'hAA; step();
    push = 1'b0; pop = 1'b0;
    check("swap.valid", 64'(pop_valid), 64'd1);
    check("swap.data",  64'(pop_data),  64'd31);
    check("swap.top",   64'(top),       64'hAA);
    check("swap.count", 64'(count),     64'd32);
    check("swap.ovf",   64'(err_ovf),   64'd0);

    // Drain: 0xAA first, then 30 down to 0.
    pop = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check($sformatf("drain%0d", i), 64'(pop_data), (i == 0) ? 64'hAA : 64'(30 - (i - 1)));
    end
    check("drain.empty", 64'(empty), 64'd1);
    // Pop on empty: ignored, flags underflow.
    step();
    pop = 1'b0;
    check("unf.flag",  64'(err_unf),   64'd1);
    check("unf.valid", 64'(pop_valid), 64'd0);
    check("unf.count", 64'(count),     64'd0);
    // clr_err together with a new underflow keeps the flag set.
    pop = 1'b1; clr_err = 1'b1; step();
    pop = 1'b0;
    check("unf.clr_and_set", 64'(err_unf), 64'd1);
    step(); clr_err = 1'b0;
    check("unf.clr", 64'(err_unf), 64'd0);

    // Push+pop on empty: push accepted, pop rejected.
    push = 1'b1; pop = 1'b1; push_data = 32'h55; step();
    push = 1'b0; pop = 1'b0;
    check("swap0.unf",   64'(err_unf),   64'd1);
    check("swap0.valid", 64'(pop_valid), 64'd0);
    check("swap0.count", 64'(count),     64'd1);
    check("swap0.top",   64'(top),       64'h55);

    // Grow to 5 entries, then reset in the middle of a pop cycle.
    push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_data = 32'(8'hC0 + i); step();
    end
    push = 1'b0;
    check("pre_rst.count", 64'(count), 64'd5);
    pop = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    pop = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("post_rst.valid1", 64'(pop_valid), 64'd0);
    step();
    check("post_rst.valid2", 64'(pop_valid), 64'd0);
    check("post_rst.top",    64'(top),       64'd0);
    check("post_rst.data",   64'(pop_data),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
